// File: rtl/handshake_fifo_buffer.sv
// Elastic in-order FIFO with registered ins_ready/outs_valid, so neither
// handshake path is combinational from input to output.
module handshake_fifo_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLOTS  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready
);
  localparam int PW = $clog2(NUM_SLOTS);
  localparam int CW = $clog2(NUM_SLOTS + 1);

  logic [NUM_SLOTS-1:0][DATA_WIDTH-1:0] slot_q;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ins_ready_q, outs_valid_q;
  logic          push, pop;

  assign push = ins_valid && ins_ready_q;
  assign pop  = outs_valid_q && outs_ready;

  // Explicit wrap at NUM_SLOTS-1 keeps non-power-of-two depths legal.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = (wr_ptr_q == PW'(NUM_SLOTS - 1)) ? '0 : wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == PW'(NUM_SLOTS - 1)) ? '0 : rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      slot_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ins_ready_q  <= 1'b0;
      outs_valid_q <= 1'b0;
    end else begin
      if (push) slot_q[wr_ptr_q] <= ins;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ins_ready_q  <= (count_d != CW'(NUM_SLOTS));
      outs_valid_q <= (count_d != '0);
    end
  end

  assign outs       = slot_q[rd_ptr_q];
  assign ins_ready  = ins_ready_q;
  assign outs_valid = outs_valid_q;
endmodule

// File: tb/tb_handshake_fifo_buffer.sv
// Scoreboard bench: a queue model of each FIFO tracks accepted tokens and
// expected handshake state; a negedge monitor compares the DUT against it.
module tb_handshake_fifo_buffer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // DUT A: 30-bit, 4 slots (directed + random)
  logic [29:0] ins_a = '0, outs_a;
  logic        ivld_a = 1'b0, irdy_a, ovld_a, ordy_a = 1'b0;
  // DUT B: 8-bit, 3 slots (random stalls, exercises wrap)
  logic [7:0]  ins_b = '0, outs_b;
  logic        ivld_b = 1'b0, irdy_b, ovld_b, ordy_b = 1'b0;

  handshake_fifo_buffer #(.DATA_WIDTH(30), .NUM_SLOTS(4)) dut_a (
    .clk(clk), .rst(rst), .ins(ins_a), .ins_valid(ivld_a), .ins_ready(irdy_a),
    .outs(outs_a), .outs_valid(ovld_a), .outs_ready(ordy_a));

  handshake_fifo_buffer #(.DATA_WIDTH(8), .NUM_SLOTS(3)) dut_b (
    .clk(clk), .rst(rst), .ins(ins_b), .ins_valid(ivld_b), .ins_ready(irdy_b),
    .outs(outs_b), .outs_valid(ovld_b), .outs_ready(ordy_b));

  int errors = 0;
  int checks = 0;
  int popped_b = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Reference models: a token is accepted when the producer offers it, the
  // buffer has not just left reset, and fewer than depth tokens are held.
  logic [29:0] qa[$];
  logic [7:0]  qb[$];
  bit jr_a = 1'b1, jr_b = 1'b1;

  always @(posedge clk) begin
    if (!rst) begin
      qa.delete(); qb.delete();
      jr_a = 1'b1; jr_b = 1'b1;
    end else begin
      automatic bit pa  = (qa.size() > 0) && ordy_a;
      automatic bit sa  = ivld_a && !jr_a && (qa.size() < 4);
      automatic bit pb  = (qb.size() > 0) && ordy_b;
      automatic bit sb  = ivld_b && !jr_b && (qb.size() < 3);
      if (pa) void'(qa.pop_front());
      if (sa) qa.push_back(ins_a);
      if (pb) begin void'(qb.pop_front()); popped_b++; end
      if (sb) qb.push_back(ins_b);
      jr_a = 1'b0; jr_b = 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("a_outs_valid", {31'd0, ovld_a}, {31'd0, qa.size() > 0});
    chk("a_ins_ready",  {31'd0, irdy_a}, {31'd0, !jr_a && qa.size() < 4});
    if (qa.size() > 0) chk("a_outs_data", {2'd0, outs_a}, {2'd0, qa[0]});
    if (jr_a) chk("a_outs_reset_zero", {2'd0, outs_a}, 32'd0);
    chk("b_outs_valid", {31'd0, ovld_b}, {31'd0, qb.size() > 0});
    chk("b_ins_ready",  {31'd0, irdy_b}, {31'd0, !jr_b && qb.size() < 3});
    if (qb.size() > 0) chk("b_outs_data", {24'd0, outs_b}, {24'd0, qb[0]});
    if (jr_b) chk("b_outs_reset_zero", {24'd0, outs_b}, 32'd0);
  end

  task automatic cyc_a(input logic v, input logic [29:0] d, input logic r);
    ivld_a = v; ins_a = d; ordy_a = r;
    @(posedge clk); #1;
  endtask

  // DUT B sees random stalls for the whole run
  initial begin
    forever begin
      @(posedge clk); #1;
      ivld_b = ($urandom_range(0, 99) < 55);
      ordy_b = ($urandom_range(0, 99) < 50);
      if (ivld_b && !irdy_b) ; // hold token stable while stalled
      else ins_b = 8'($urandom);
    end
  end

  initial begin
    // reset held for two edges, then single token with consumer stalled
    rst = 1'b0;
    repeat (2) cyc_a(1'b0, '0, 1'b0);
    rst = 1'b1;
    cyc_a(1'b0, '0, 1'b0);
    cyc_a(1'b1, 30'h17BF3E7B, 1'b0);
    cyc_a(1'b0, '0, 1'b0);
    cyc_a(1'b0, '0, 1'b1);

    // fill to full, hold token 5 against backpressure, then drain
    for (int i = 1; i <= 4; i++) cyc_a(1'b1, 30'(i), 1'b0);
    repeat (2) cyc_a(1'b1, 30'd5, 1'b0);
    repeat (2) cyc_a(1'b1, 30'd5, 1'b1);
    repeat (5) cyc_a(1'b0, '0, 1'b1);

    // streaming 0..19
    for (int i = 0; i < 20; i++) cyc_a(1'b1, 30'(i), 1'b1);
    repeat (2) cyc_a(1'b0, '0, 1'b1);

    // simultaneous push/pop at occupancy 2
    cyc_a(1'b1, 30'h100, 1'b0);
    cyc_a(1'b1, 30'h101, 1'b0);
    for (int i = 0; i < 3; i++) cyc_a(1'b1, 30'h200 + 30'(i), 1'b1);
    repeat (4) cyc_a(1'b0, '0, 1'b1);

    // mid-operation reset with three tokens held
    for (int i = 0; i < 3; i++) cyc_a(1'b1, 30'h3AA0 + 30'(i), 1'b0);
    rst = 1'b0;
    cyc_a(1'b1, 30'h3FFF, 1'b1);
    rst = 1'b1;
    repeat (2) cyc_a(1'b0, '0, 1'b1);
    cyc_a(1'b1, 30'h1234, 1'b1);
    repeat (2) cyc_a(1'b0, '0, 1'b1);

    // random traffic on A
    for (int i = 0; i < 300; i++) begin
      automatic logic v = ($urandom_range(0, 99) < 60);
      if (!(ivld_a && !irdy_a)) ins_a = 30'($urandom);
      cyc_a(v || (ivld_a && !irdy_a), ins_a, ($urandom_range(0, 99) < 50));
    end
    repeat (6) cyc_a(1'b0, '0, 1'b1);

    chk("b_min_tokens_delivered", {31'd0, popped_b >= 10}, 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
